sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock FIFO for the in-domain buffering paths. Parametrised width and depth.
//  Adds occupancy count, programmable almost-full/almost-empty flags and overflow/underflow pulses.
//  Optional first-word-fall-through (FWFT) read mode. Binary pointers; no CDC logic.
// PARAMETERS
//  DATA_WIDTH     64  word width in bits
//  ADDR_WIDTH     4   log2 of depth; DEPTH = 2**ADDR_WIDTH
//  AFULL_THRESH   DEPTH-2  almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
//  AEMPTY_THRESH  1   almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1             sole clock, rising edge
//  rst           in   1             asynchronous, active-high reset
//  wdata         in   DATA_WIDTH    write data, sampled with winc
//  winc          in   1             push request
//  rinc          in   1             pop request
//  rdata         out  DATA_WIDTH    read data
//  wfull         out  1             count == DEPTH
//  rempty        out  1             count == 0
//  almost_full   out  1             count >= AFULL_THRESH
//  almost_empty  out  1             count <= AEMPTY_THRESH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             1-cycle pulse: winc while wfull (write dropped)
//  underflow     out  1             1-cycle pulse: rinc while rempty (read ignored)
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is asynchronous, active-high.
//  - Pointers: wptr and rptr are ADDR_WIDTH+1 bits. Memory index is the low ADDR_WIDTH bits.
//    The MSB is a wrap bit; pointers wrap modulo 2*DEPTH.
//  - Push/pop acceptance:
//    - Write accepted iff winc && !wfull. Read accepted iff rinc && !rempty.
//    - Flags are evaluated on pre-edge state, so a push on a full FIFO is dropped even if a pop
//      is accepted in the same cycle.
//  - count: registered. +1 on write only, -1 on read only, unchanged on both or neither.
//    All flags are decoded from the count register, so they update on the same edge as count.
//  - Write latency: word written at edge N. rempty deasserts after edge N; word is readable in cycle N+1.
//  - Standard mode (no macro):
//    - rdata is a register loaded from mem[raddr] on an accepted read, i.e. 1-cycle read latency.
//    - rdata holds its value otherwise, including on underflow.
//  - Boundaries:
//    - Full + winc + rinc: read accepted, write dropped, overflow=1, count = DEPTH-1.
//    - Empty + winc + rinc: write accepted, read ignored, underflow=1, count=1.
//    - Pointer wrap is seamless; there is no bubble at the DEPTH-1 -> 0 index.
//  - Reset (at any time, including mid-burst):
//    - Values: wptr = rptr = 0, count = 0, rempty = 1, wfull = 0, almost_full = 0,
//      almost_empty = 1, overflow = underflow = 0, rdata = 0.
//    - Memory contents are not cleared and are not observable after reset.
// CONFIGURATION
//  - FIFO_FWFT_EN defined:
//    - rdata = mem[raddr] combinationally; the head word is valid whenever !rempty.
//    - rinc acknowledges and pops it; the next word appears in the following cycle.
//    - rdata is don't-care while rempty.
//  - Undefined: standard registered-read mode as above.
//  - Flags, count and the acceptance rules are identical in both modes.
// STRUCTURE
//  - Package sync_fifo_pkg holds:
//    - function clog2-free helpers: depth_f(ADDR_WIDTH)
//    - typedef for pointer/count width
//    - localparam checks: AFULL_THRESH in range; AEMPTY_THRESH < AFULL_THRESH
//  - One sub-module, sync_fifo_mem: DEPTH x DATA_WIDTH register array.
//    - Synchronous write port; combinational read port.
//    - The top-level wraps its read port in a register for standard mode.
//  - Top-level holds pointers, count, flag decode, error pulses and the rdata register.
// TESTING  (DATA_WIDTH=8, ADDR_WIDTH=2 -> DEPTH=4, AFULL=3, AEMPTY=1)
//  1. Reset, idle -> rempty=1, almost_empty=1, wfull=0, count=0, rdata=0.
//  2. Push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops after 2nd push;
//     almost_full rises after 3rd; wfull after 4th.
//     Then pop 4 -> 0x11..0x44 in order; standard mode shows each one cycle after rinc.
//  3. Full, winc+rinc with wdata=0x55 -> overflow pulse, count=3, 0x55 never read;
//     empty, winc+rinc with 0x66 -> underflow pulse, count=1, next pop returns 0x66.
//  4. Six push/pop pairs spanning index wrap -> data order preserved, count constant,
//     no overflow/underflow.
//  5. Assert rst mid-burst (count=2) asynchronously between edges -> outputs reach reset
//     values before the next edge. Post-reset push 0x77/pop returns 0x77.
//  6. FIFO_FWFT_EN: push 0xA5 to empty -> rdata=0xA5 the cycle rempty falls, without rinc;
//     rinc -> rempty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: depth derivation, pointer type, parameter checks.
// No logic; elaboration-time only.
// Used by sync_fifo and sync_fifo_mem through a wildcard import.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 4;

  // Pointer/count type for the default configuration (wrap bit + index).
  typedef logic [DEF_ADDR_WIDTH:0] def_ptr_t;

  // Number of entries for a given address width.
  function automatic int depth_f(input int aw);
    return 1 << aw;
  endfunction

  // almost_full threshold must lie in 1..DEPTH.
  function automatic bit afull_thresh_ok(input int aw, input int afull);
    return (afull >= 1) && (afull <= depth_f(aw));
  endfunction

  // almost_empty threshold must lie in 0..DEPTH-1 and sit below almost_full.
  function automatic bit aempty_thresh_ok(input int aw, input int aempty, input int afull);
    return (aempty >= 0) && (aempty <= depth_f(aw) - 1) && (aempty < afull);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, combinational read.
// Read data valid in the same cycle as the address; write lands on the clock edge.
// No flow control here; the caller only asserts i_we for accepted pushes.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset; stale contents are never exposed after reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Read latency 1 cycle (registered rdata), or 0 cycles with FIFO_FWFT_EN defined.
// Pushes on full and pops on empty are dropped and flagged with a 1-cycle pulse.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = depth_f(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t C_DEPTH  = cnt_t'(DEPTH);
  localparam cnt_t C_AFULL  = cnt_t'(AFULL_THRESH);
  localparam cnt_t C_AEMPTY = cnt_t'(AEMPTY_THRESH);

  if (!afull_thresh_ok(ADDR_WIDTH, AFULL_THRESH)) begin : g_bad_afull
    $error("sync_fifo: AFULL_THRESH must be in 1..DEPTH");
  end
  if (!aempty_thresh_ok(ADDR_WIDTH, AEMPTY_THRESH, AFULL_THRESH)) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1 and below AFULL_THRESH");
  end

  cnt_t                  r_wptr;
  cnt_t                  r_rptr;
  cnt_t                  r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Flags come from the pre-edge count, so a pop never frees room for a same-cycle push.
  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Pointers advance on accepted operations; the extra MSB wraps modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Occupancy: simultaneous accepted push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error pulses register the dropped request so they line up with the count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= winc && w_full;
      r_underflow <= rinc && w_empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; it is meaningless while the FIFO is empty.
  assign rdata = w_mem_rdata;
`else
  logic [DATA_WIDTH-1:0] r_rdata;

  // Registered read: load the head on an accepted pop, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= w_mem_rdata;
    end
  end

  assign rdata = r_rdata;
`endif

  assign count        = r_count;
  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, AFULL=3, AEMPTY=1) with a queue-based reference model.
// Build with FIFO_FWFT_EN defined to exercise the fall-through read mode.
// The model is compared every cycle; literal expectations pin key points of the sequence.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  sync_fifo #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (2),
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wdata        (wdata),
    .winc         (winc),
    .rinc         (rinc),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the registered side effects of each edge.
  logic [7:0] mq[$];
  logic [7:0] m_rdata;
  logic       m_ovf, m_unf;

  always @(posedge clk or posedge rst) begin : mdl
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete();
      m_rdata <= 8'h00;
      m_ovf   <= 1'b0;
      m_unf   <= 1'b0;
    end else begin
      m_ovf <= winc && (n == 4);
      m_unf <= rinc && (n == 0);
      if (rinc && n != 0) m_rdata <= mq.pop_front();
      if (winc && n != 4) mq.push_back(wdata);
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      int n;
      n = mq.size();
      check("m_count",     {29'b0, count},  n);
      check("m_wfull",     {31'b0, wfull},  (n == 4));
      check("m_rempty",    {31'b0, rempty}, (n == 0));
      check("m_afull",     {31'b0, almost_full},  (n >= 3));
      check("m_aempty",    {31'b0, almost_empty}, (n <= 1));
      check("m_overflow",  {31'b0, overflow},  m_ovf);
      check("m_underflow", {31'b0, underflow}, m_unf);
`ifdef FIFO_FWFT_EN
      if (n != 0) check("m_rdata_fwft", {24'b0, rdata}, mq[0]);
`else
      check("m_rdata", {24'b0, rdata}, m_rdata);
`endif
    end
  end

  // One clock cycle with the given request pattern; returns 1 time unit after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  // Pop (optionally with a push) and check the popped word where the mode presents it.
  task automatic pop_chk(input bit w, input logic [7:0] d, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    check("pop_head", {24'b0, rdata}, {24'b0, exp});
    step(w, d, 1'b1);
`else
    step(w, d, 1'b1);
    check("pop_rdata", {24'b0, rdata}, {24'b0, exp});
`endif
  endtask

  initial begin
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;

    // 1. Reset state
    check("rst_rempty", {31'b0, rempty}, 1);
    check("rst_aempty", {31'b0, almost_empty}, 1);
    check("rst_wfull",  {31'b0, wfull}, 0);
    check("rst_count",  {29'b0, count}, 0);
`ifndef FIFO_FWFT_EN
    check("rst_rdata",  {24'b0, rdata}, 0);
`endif
    chk_en = 1'b1;
    step(0, 8'h00, 0);

    // 2. Fill, watching flag thresholds, then drain in order
    step(1, 8'h11, 0);
    check("p1_count", {29'b0, count}, 1);
    check("p1_aempty", {31'b0, almost_empty}, 1);
    step(1, 8'h22, 0);
    check("p2_aempty", {31'b0, almost_empty}, 0);
    check("p2_afull", {31'b0, almost_full}, 0);
    step(1, 8'h33, 0);
    check("p3_afull", {31'b0, almost_full}, 1);
    check("p3_wfull", {31'b0, wfull}, 0);
    step(1, 8'h44, 0);
    check("p4_count", {29'b0, count}, 4);
    check("p4_wfull", {31'b0, wfull}, 1);
    pop_chk(0, 8'h00, 8'h11);
    pop_chk(0, 8'h00, 8'h22);
    pop_chk(0, 8'h00, 8'h33);
    pop_chk(0, 8'h00, 8'h44);
    check("drain_rempty", {31'b0, rempty}, 1);

    // 3. Overflow on full with simultaneous pop; underflow on empty with simultaneous push
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
    pop_chk(1, 8'h55, 8'h01);
    check("ovf_pulse", {31'b0, overflow}, 1);
    check("ovf_count", {29'b0, count}, 3);
    pop_chk(0, 8'h00, 8'h02);
    check("ovf_clear", {31'b0, overflow}, 0);
    pop_chk(0, 8'h00, 8'h03);
    pop_chk(0, 8'h00, 8'h04);
    check("ovf_empty", {31'b0, rempty}, 1);
    step(1, 8'h66, 1);
    check("unf_pulse", {31'b0, underflow}, 1);
    check("unf_count", {29'b0, count}, 1);
    pop_chk(0, 8'h00, 8'h66);

    // 4. Push/pop pairs across the index wrap keep order and occupancy
    step(1, 8'h80, 0);
    for (int i = 0; i < 6; i++) begin
      pop_chk(1, 8'(8'h81 + i), 8'(8'h80 + i));
      check("wrap_count", {29'b0, count}, 1);
    end
    pop_chk(0, 8'h00, 8'h86);

    // 5. Asynchronous reset mid-burst
    step(1, 8'h90, 0);
    step(1, 8'h91, 0);
    check("pre_rst_count", {29'b0, count}, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",  {29'b0, count}, 0);
    check("arst_rempty", {31'b0, rempty}, 1);
    check("arst_aempty", {31'b0, almost_empty}, 1);
    check("arst_afull",  {31'b0, almost_full}, 0);
    check("arst_wfull",  {31'b0, wfull}, 0);
    check("arst_pulses", {30'b0, overflow, underflow}, 0);
`ifndef FIFO_FWFT_EN
    check("arst_rdata",  {24'b0, rdata}, 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    step(1, 8'h77, 0);
    pop_chk(0, 8'h00, 8'h77);

`ifdef FIFO_FWFT_EN
    // 6. Fall-through: head visible as soon as rempty falls, popped by rinc
    step(1, 8'hA5, 0);
    check("fwft_rempty", {31'b0, rempty}, 0);
    check("fwft_head",   {24'b0, rdata}, 8'hA5);
    step(0, 8'h00, 1);
    check("fwft_popped", {31'b0, rempty}, 1);
`endif

    step(0, 8'h00, 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
